// File: rtl/bsg_cam_1r1w_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_cam_1r1w_write_ctrl
//  Purpose  : Write-port controller for a 1R1W CAM tag array. Arbitrates
//             flush-all (sequenced one entry per cycle), multi-entry clear and
//             allocate (lowest empty entry, or round-robin victim when full).
//  Config   : define BSG_CAM_1R1W_WRITE_CTRL_EVICT_EN to allow allocation into
//             a full array by evicting the entry under a rotating victim
//             pointer; otherwise allocation stalls while the array is full.
//  Revision : 1.0 - initial release
// ============================================================================
module bsg_cam_1r1w_write_ctrl #(
    parameter els_p   = "inv",
    parameter width_p = "inv"
) (
    input  logic               clk_i,
    input  logic               reset_i,

    input  logic               alloc_v_i,
    input  logic [width_p-1:0] alloc_tag_i,
    output logic               alloc_ready_o,
    output logic [els_p-1:0]   alloc_way_o,

    output logic               evict_v_o,
    output logic [els_p-1:0]   evict_way_o,

    input  logic               clear_v_i,
    input  logic [els_p-1:0]   clear_way_i,

    input  logic               flush_v_i,
    output logic               flush_busy_o,

    output logic [els_p-1:0]   w_v_o,
    output logic               w_set_not_clear_o,
    output logic [width_p-1:0] w_tag_o,
    input  logic [els_p-1:0]   w_empty_i
);

    localparam logic [els_p-1:0] ONE_HOT_0 = {{(els_p-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e             state_q;
    logic [els_p-1:0]   flush_step_q;   // one-hot entry being cleared this flush cycle
    logic               flush_busy_q;

    logic               idle_w;
    logic               any_empty_w;
    logic [els_p-1:0]   lowest_empty_w;
    logic               can_alloc_w;
    logic               evicting_w;
    logic [els_p-1:0]   target_w;
    logic               handshake_w;

    // Flush sequencer: one cycle per entry, step pointer rotates back to entry 0 on exit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            flush_step_q <= ONE_HOT_0;
            flush_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_v_i) begin
                        state_q      <= FLUSH;
                        flush_step_q <= ONE_HOT_0;
                        flush_busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    flush_step_q <= {flush_step_q[els_p-2:0], flush_step_q[els_p-1]};
                    if (flush_step_q[els_p-1]) begin
                        state_q      <= IDLE;
                        flush_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    flush_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign idle_w         = (state_q == IDLE) & ~reset_i;
    assign any_empty_w    = |w_empty_i;
    // Isolate the lowest set bit: x & (-x)
    assign lowest_empty_w = w_empty_i & (~w_empty_i + ONE_HOT_0);

`ifdef BSG_CAM_1R1W_WRITE_CTRL_EVICT_EN
    logic [els_p-1:0] victim_q;         // one-hot round-robin victim pointer

    assign can_alloc_w = 1'b1;
    assign evicting_w  = ~any_empty_w;
    assign target_w    = evicting_w ? victim_q : lowest_empty_w;

    // Victim pointer advances only when an allocation actually evicts
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            victim_q <= ONE_HOT_0;
        end else if (handshake_w && evicting_w) begin
            victim_q <= {victim_q[els_p-2:0], victim_q[els_p-1]};
        end
    end
`else
    assign can_alloc_w = any_empty_w;
    assign evicting_w  = 1'b0;
    assign target_w    = lowest_empty_w;
`endif

    assign alloc_ready_o = idle_w & ~flush_v_i & ~clear_v_i & can_alloc_w;
    assign handshake_w   = alloc_v_i & alloc_ready_o;
    assign flush_busy_o  = flush_busy_q & ~reset_i;
    assign w_tag_o       = alloc_tag_i;

    // Write-port mux: flush step > flush request (no write) > clear > allocate
    always_comb begin
        w_v_o             = '0;
        w_set_not_clear_o = 1'b0;
        alloc_way_o       = '0;
        evict_v_o         = 1'b0;
        evict_way_o       = '0;
        if (reset_i) begin
            w_v_o = '0;
        end else if (state_q == FLUSH) begin
            w_v_o = flush_step_q;
        end else if (flush_v_i) begin
            w_v_o = '0;
        end else if (clear_v_i) begin
            w_v_o = clear_way_i;
        end else if (handshake_w) begin
            w_v_o             = target_w;
            w_set_not_clear_o = 1'b1;
            alloc_way_o       = target_w;
            evict_v_o         = evicting_w;
            evict_way_o       = evicting_w ? target_w : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_cam_1r1w_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_cam_1r1w_write_ctrl
//  Purpose  : Self-checking bench for bsg_cam_1r1w_write_ctrl (els_p=4,
//             width_p=8), both with and without BSG_CAM_1R1W_WRITE_CTRL_EVICT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_cam_1r1w_write_ctrl;

    localparam int ELS = 4;
    localparam int W   = 8;
`ifdef BSG_CAM_1R1W_WRITE_CTRL_EVICT_EN
    localparam bit EV = 1'b1;
`else
    localparam bit EV = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_i, alloc_v_i, clear_v_i, flush_v_i;
    logic [W-1:0]   alloc_tag_i;
    logic [ELS-1:0] clear_way_i, w_empty_i;
    logic           alloc_ready_o, evict_v_o, flush_busy_o, w_set_not_clear_o;
    logic [ELS-1:0] alloc_way_o, evict_way_o, w_v_o;
    logic [W-1:0]   w_tag_o;

    always #5 clk = ~clk;

    bsg_cam_1r1w_write_ctrl #(.els_p(ELS), .width_p(W)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .alloc_v_i(alloc_v_i), .alloc_tag_i(alloc_tag_i), .alloc_ready_o(alloc_ready_o),
        .alloc_way_o(alloc_way_o), .evict_v_o(evict_v_o), .evict_way_o(evict_way_o),
        .clear_v_i(clear_v_i), .clear_way_i(clear_way_i),
        .flush_v_i(flush_v_i), .flush_busy_o(flush_busy_o),
        .w_v_o(w_v_o), .w_set_not_clear_o(w_set_not_clear_o), .w_tag_o(w_tag_o),
        .w_empty_i(w_empty_i)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: remaining flush cycles and victim index as plain integers
    int m_flush_rem = 0;
    int m_victim    = 0;
    logic [ELS-1:0] e_wv, e_way, e_evway;
    logic           e_set, e_ready, e_evv, e_busy, e_hs, e_evicting;

    task automatic model_eval();
        e_wv = '0; e_way = '0; e_evway = '0;
        e_set = 0; e_ready = 0; e_evv = 0; e_busy = 0; e_hs = 0; e_evicting = 0;
        if (reset_i) return;
        if (m_flush_rem > 0) begin
            e_busy = 1;
            e_wv   = ELS'(1) << (ELS - m_flush_rem);
            return;
        end
        e_ready = !flush_v_i && !clear_v_i && ((w_empty_i != 0) || EV);
        if (flush_v_i) return;
        if (clear_v_i) begin
            e_wv = clear_way_i;
            return;
        end
        if (alloc_v_i && e_ready) begin
            logic [ELS-1:0] tgt;
            e_hs = 1;
            tgt  = '0;
            if (w_empty_i != 0) begin
                for (int i = ELS - 1; i >= 0; i--) if (w_empty_i[i]) tgt = ELS'(1) << i;
            end else begin
                tgt        = ELS'(1) << m_victim;
                e_evicting = 1;
            end
            e_wv  = tgt;
            e_way = tgt;
            e_set = 1;
            e_evv = e_evicting;
            e_evway = e_evicting ? tgt : '0;
        end
    endtask

    task automatic model_update();
        if (reset_i) begin
            m_flush_rem = 0;
            m_victim    = 0;
        end else if (m_flush_rem > 0) begin
            m_flush_rem--;
        end else if (flush_v_i) begin
            m_flush_rem = ELS;
        end else if (e_hs && e_evicting) begin
            m_victim = (m_victim + 1) % ELS;
        end
    endtask

    // Called at a negedge with inputs already applied; checks, then advances one cycle
    task automatic cycle(input string nm);
        #1;
        model_eval();
        chk({nm, ".w_v"},      32'(w_v_o),             32'(e_wv));
        chk({nm, ".set"},      32'(w_set_not_clear_o), 32'(e_set));
        chk({nm, ".ready"},    32'(alloc_ready_o),     32'(e_ready));
        chk({nm, ".way"},      32'(alloc_way_o),       32'(e_way));
        chk({nm, ".evict_v"},  32'(evict_v_o),         32'(e_evv));
        chk({nm, ".evict_way"},32'(evict_way_o),       32'(e_evway));
        chk({nm, ".busy"},     32'(flush_busy_o),      32'(e_busy));
        chk({nm, ".tag"},      32'(w_tag_o),           32'(alloc_tag_i));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset_i = 0; alloc_v_i = 0; clear_v_i = 0; flush_v_i = 0;
        alloc_tag_i = '0; clear_way_i = '0; w_empty_i = '1;
    endtask

    typedef struct {
        logic           alloc_v;
        logic [W-1:0]   tag;
        logic [ELS-1:0] empty;
        logic           clear_v;
        logic [ELS-1:0] clear_way;
        logic [ELS-1:0] exp_wv;
        logic           exp_set;
        logic           exp_ready;
        logic [ELS-1:0] exp_way;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 1'b1, 4'b0001};
        vecs[1] = '{1'b1, 8'h3C, 4'b1010, 1'b0, 4'b0000, 4'b0010, 1'b1, 1'b1, 4'b0010};
        vecs[2] = '{1'b1, 8'h11, 4'b1111, 1'b1, 4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0000};
        vecs[3] = '{1'b0, 8'h22, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000};
        vecs[4] = '{1'b1, 8'h5A, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1, 4'b1000};
        vecs[5] = '{1'b0, 8'h00, 4'b0101, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0000};

        idle_inputs();
        reset_i = 1;
        @(negedge clk);
        cycle("reset0");
        cycle("reset1");
        reset_i = 0;

        // Table-driven single-cycle vectors from the post-reset IDLE state
        foreach (vecs[i]) begin
            alloc_v_i = vecs[i].alloc_v; alloc_tag_i = vecs[i].tag; w_empty_i = vecs[i].empty;
            clear_v_i = vecs[i].clear_v; clear_way_i = vecs[i].clear_way;
            #1;
            chk($sformatf("vec%0d.w_v", i),   32'(w_v_o),             32'(vecs[i].exp_wv));
            chk($sformatf("vec%0d.set", i),   32'(w_set_not_clear_o), 32'(vecs[i].exp_set));
            chk($sformatf("vec%0d.ready", i), 32'(alloc_ready_o),     32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d.way", i),   32'(alloc_way_o),       32'(vecs[i].exp_way));
            chk($sformatf("vec%0d.evv", i),   32'(evict_v_o),         32'h0);
            #1;
            cycle($sformatf("vec%0d", i));
        end
        idle_inputs();

        // Full array: three back-to-back allocations
        for (int k = 0; k < 3; k++) begin
            alloc_v_i = 1; alloc_tag_i = 8'(8'h40 + k); w_empty_i = '0;
            #1;
            if (EV) begin
                chk($sformatf("full%0d.evict_way", k), 32'(evict_way_o), 32'(1 << k));
                chk($sformatf("full%0d.evict_v", k),   32'(evict_v_o),   32'h1);
            end else begin
                chk($sformatf("full%0d.ready", k), 32'(alloc_ready_o), 32'h0);
                chk($sformatf("full%0d.w_v", k),   32'(w_v_o),         32'h0);
            end
            #1;
            cycle($sformatf("full%0d", k));
        end
        idle_inputs();

        // Flush pulse followed by four sequenced clears; requests during flush ignored
        flush_v_i = 1; alloc_v_i = 1;
        cycle("flush_req");
        flush_v_i = 1; clear_v_i = 1; clear_way_i = 4'b1111;
        for (int k = 0; k < ELS; k++) begin
            #1;
            chk($sformatf("flush%0d.w_v", k),   32'(w_v_o),         32'(1 << k));
            chk($sformatf("flush%0d.busy", k),  32'(flush_busy_o),  32'h1);
            chk($sformatf("flush%0d.ready", k), 32'(alloc_ready_o), 32'h0);
            #1;
            cycle($sformatf("flush%0d", k));
        end
        idle_inputs();
        #1;
        chk("post_flush.busy",  32'(flush_busy_o),  32'h0);
        chk("post_flush.ready", 32'(alloc_ready_o), 32'h1);
        #1;
        cycle("post_flush");

        // Reset on flush cycle 2 abandons the flush and resets the victim pointer
        flush_v_i = 1;
        cycle("fr_req");
        flush_v_i = 0;
        cycle("fr0");
        cycle("fr1");
        reset_i = 1;
        cycle("fr2_reset");
        reset_i = 0;
        #1;
        chk("after_reset.busy", 32'(flush_busy_o), 32'h0);
        chk("after_reset.w_v",  32'(w_v_o),        32'h0);
        #1;
        cycle("after_reset");
        alloc_v_i = 1; w_empty_i = '0; alloc_tag_i = 8'hEE;
        #1;
        if (EV) chk("victim_reset.evict_way", 32'(evict_way_o), 32'h1);
        else    chk("victim_reset.ready",     32'(alloc_ready_o), 32'h0);
        #1;
        cycle("victim_reset");
        idle_inputs();

        // Randomised traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            reset_i     = ($urandom_range(0, 39) == 0);
            flush_v_i   = ($urandom_range(0, 19) == 0);
            clear_v_i   = ($urandom_range(0, 5) == 0);
            clear_way_i = ELS'($urandom);
            alloc_v_i   = $urandom_range(0, 1) != 0;
            alloc_tag_i = W'($urandom);
            w_empty_i   = ($urandom_range(0, 3) == 0) ? '0 : ELS'($urandom);
            cycle($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
